seq_pc_controller: RTL and testbench
====================================

Name: seq_pc_controller

Overview:
Sequencing controller for the single-cycle-datapath SEQ Y86-64 core. It owns the architectural PC register and steps the datapath through fetch, decode, execute, memory, writeback and PC-update, one stage per cycle. It stalls in the memory stage on a data-memory handshake and loads the PC from the PC_update combinational result. It also tracks the Y86 status code (AOK/HLT/ADR/INS) and freezes the core on any non-AOK status.

Parameters:
PC_WIDTH, 64, width of PC and next_pc
RESET_PC, 64'd0, PC value loaded on reset
MEM_TIMEOUT, 15, max cycles mem_req may wait for mem_ack before an ADR fault (range 1..255)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  begin execution from IDLE; ignored in any other state
icode  input  4  instruction code from fetch, sampled in FETCH
imem_error  input  1  fetch address invalid, sampled in FETCH
next_pc  input  PC_WIDTH  NextPC from the PC_update block
mem_ack  input  1  data memory access complete
dmem_error  input  1  data memory address invalid
pc  output  PC_WIDTH  architectural PC
fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en  output  1 each  one-hot stage enables
cc_we  output  1  condition-code write enable
mem_req  output  1  data memory request
stat  output  3  status: 1=AOK 2=HLT 3=ADR 4=INS
halted  output  1  core frozen
instr_count  output  32  retired instruction count

Behaviour:
- Reset: synchronous and active-low; any edge with rst_n=0 overrides everything, including mid-instruction and mid-memory-wait.
  - Reset values: pc=RESET_PC, state=IDLE, stat=1, halted=0, instr_count=0, timeout counter=0, and all enables, cc_we and mem_req =0.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT.
- Stage enables: exactly one stage enable is high in each corresponding state. None are high in IDLE or HALT.
- IDLE: go to FETCH when start=1.
- FETCH, evaluated in priority order:
  1. imem_error=1 → stat=3 (ADR).
  2. icode>4'hB → stat=4 (INS).
  3. icode=4'h0 → stat=2 (HLT).
  4. Otherwise go to DECODE.
  - In cases 1–3 the next state is HALT. The icode is registered internally for the rest of the instruction.
- DECODE → EXECUTE.
- EXECUTE: cc_we=1 for that single cycle iff the registered icode=6 (OPq). Then go to MEMORY.
- MEMORY for memory icodes (4 rmmovq, 5 mrmovq, 8 call, 9 ret, 10 pushq, 11 popq):
  - mem_req=1 combinationally while in MEMORY.
  - Go to WRITEBACK on the cycle mem_ack=1.
  - dmem_error=1 → stat=3, HALT. This wins over a simultaneous mem_ack.
  - The timeout counter increments on each MEMORY cycle without ack. When it reaches MEM_TIMEOUT, set stat=3 and go to HALT. The counter clears on leaving MEMORY.
- MEMORY for all other icodes: mem_req=0, one cycle, then WRITEBACK. mem_ack and dmem_error are ignored.
- WRITEBACK → PCUPD.
- PCUPD:
  - pc <= next_pc, taken exactly as presented with no width change or alignment check.
  - instr_count += 1, wrapping modulo 2^32.
  - Then go to FETCH.
- Latency: a non-memory instruction takes exactly 6 cycles from FETCH entry to the next FETCH. A memory instruction takes 6 + (cycles waiting for mem_ack).
- HALT:
  - halted=1; pc, stat and instr_count hold.
  - A halting instruction does not advance pc or increment instr_count.
  - Only reset leaves HALT; start is ignored.
- stat changes only on a fault transition or reset and never returns to AOK without reset.

Test Plan:
- Reset then start, icode=2 (rrmovq), next_pc=200 → fetch_en..pc_en each high one cycle in order; pc=200 six cycles after FETCH entry; instr_count=1; mem_req never asserted.
- icode=6, next_pc=10 → cc_we high exactly in the EXECUTE cycle; pc=10; next FETCH follows immediately.
- icode=5 (mrmovq), mem_ack delayed 3 cycles, next_pc=6 → mem_req high 4 cycles; instruction takes 9 cycles; pc=6.
- icode=8 (call), mem_ack never arrives, MEM_TIMEOUT=15 → stat=3, halted=1 after 15 MEMORY cycles; pc unchanged; start pulse ignored.
- icode=0 at pc=0x40 → stat=2, halted=1, pc stays 0x40, instr_count unchanged. icode=4'hC on a fresh run → stat=4. Same cycle as dmem_error+mem_ack → stat=3.
- rst_n=0 during MEMORY wait with mem_req=1 → on the next edge pc=RESET_PC, state IDLE, mem_req=0, stat=1, instr_count=0.

Source files
------------

// File: rtl/seq_pc_controller.sv
// Sequencing controller for the SEQ Y86-64 core: owns PC and status, and steps the datapath one stage per cycle.
// Latency: 6 cycles per instruction, plus any cycles spent waiting on mem_ack.
// Backpressure: holds in MEMORY until mem_ack, dmem_error or the wait timeout.
module seq_pc_controller #(
    parameter int                     PC_WIDTH    = 64,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter int                     MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [3:0]          icode,
    input  logic                imem_error,
    input  logic [PC_WIDTH-1:0] next_pc,
    input  logic                mem_ack,
    input  logic                dmem_error,
    output logic [PC_WIDTH-1:0] pc,
    output logic                fetch_en,
    output logic                decode_en,
    output logic                execute_en,
    output logic                memory_en,
    output logic                writeback_en,
    output logic                pc_en,
    output logic                cc_we,
    output logic                mem_req,
    output logic [2:0]          stat,
    output logic                halted,
    output logic [31:0]         instr_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE,
        S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALT
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] IC_HALT = 4'h0;
    localparam logic [3:0] IC_OPQ  = 4'h6;
    localparam logic [3:0] IC_MAX  = 4'hB;

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [2:0]          stat_q, stat_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [3:0]          icode_q, icode_d;
    logic [7:0]          tmo_q, tmo_d;
    logic                is_mem;

    always_comb begin
        is_mem = 1'b0;
        case (icode_q)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: is_mem = 1'b1;
            default:                            is_mem = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        stat_d       = stat_q;
        cnt_d        = cnt_q;
        icode_d      = icode_q;
        tmo_d        = '0;
        fetch_en     = 1'b0;
        decode_en    = 1'b0;
        execute_en   = 1'b0;
        memory_en    = 1'b0;
        writeback_en = 1'b0;
        pc_en        = 1'b0;
        cc_we        = 1'b0;
        mem_req      = 1'b0;
        halted       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                fetch_en = 1'b1;
                icode_d  = icode;
                if (imem_error) begin
                    stat_d  = STAT_ADR;
                    state_d = S_HALT;
                end else if (icode > IC_MAX) begin
                    stat_d  = STAT_INS;
                    state_d = S_HALT;
                end else if (icode == IC_HALT) begin
                    stat_d  = STAT_HLT;
                    state_d = S_HALT;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                decode_en = 1'b1;
                state_d   = S_EXECUTE;
            end
            S_EXECUTE: begin
                execute_en = 1'b1;
                cc_we      = (icode_q == IC_OPQ);
                state_d    = S_MEMORY;
            end
            S_MEMORY: begin
                memory_en = 1'b1;
                if (is_mem) begin
                    mem_req = 1'b1;
                    // A reported address fault outranks a simultaneous ack.
                    if (dmem_error) begin
                        stat_d  = STAT_ADR;
                        state_d = S_HALT;
                    end else if (mem_ack) begin
                        state_d = S_WRITEBACK;
                    end else if (tmo_q == TMO_LAST) begin
                        stat_d  = STAT_ADR;
                        state_d = S_HALT;
                    end else begin
                        tmo_d = tmo_q + 8'd1;
                    end
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                writeback_en = 1'b1;
                state_d      = S_PCUPD;
            end
            S_PCUPD: begin
                pc_en   = 1'b1;
                pc_d    = next_pc;
                cnt_d   = cnt_q + 32'd1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            stat_q  <= STAT_AOK;
            cnt_q   <= '0;
            icode_q <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stat_q  <= stat_d;
            cnt_q   <= cnt_d;
            icode_q <= icode_d;
            tmo_q   <= tmo_d;
        end
    end

    assign pc          = pc_q;
    assign stat        = stat_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_seq_pc_controller.sv
// Directed bench for seq_pc_controller: stage sequencing, memory stall/timeout, faults and reset.
module tb_seq_pc_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  icode;
    logic        imem_error;
    logic [63:0] next_pc;
    logic        mem_ack;
    logic        dmem_error;
    logic [63:0] pc;
    logic        fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en;
    logic        cc_we, mem_req, halted;
    logic [2:0]  stat;
    logic [31:0] instr_count;
    logic [5:0]  en;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] EN_F = 6'b100000;
    localparam logic [5:0] EN_D = 6'b010000;
    localparam logic [5:0] EN_E = 6'b001000;
    localparam logic [5:0] EN_M = 6'b000100;
    localparam logic [5:0] EN_W = 6'b000010;

    seq_pc_controller #(.PC_WIDTH(64), .RESET_PC(64'd0), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .icode(icode),
        .imem_error(imem_error), .next_pc(next_pc), .mem_ack(mem_ack),
        .dmem_error(dmem_error), .pc(pc), .fetch_en(fetch_en),
        .decode_en(decode_en), .execute_en(execute_en), .memory_en(memory_en),
        .writeback_en(writeback_en), .pc_en(pc_en), .cc_we(cc_we),
        .mem_req(mem_req), .stat(stat), .halted(halted), .instr_count(instr_count)
    );

    assign en = {fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read there too.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; mem_ack = 1'b0;
        dmem_error = 1'b0; imem_error = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; icode = 4'h1; imem_error = 1'b0;
        next_pc = '0; mem_ack = 1'b0; dmem_error = 1'b0;
        step();
        step();
        chk("rst_pc", pc, 64'd0);
        chk("rst_stat", stat, 3'd1);
        chk("rst_halted", halted, 1'b0);
        chk("rst_cnt", instr_count, 32'd0);
        chk("rst_en", en, 6'd0);
        chk("rst_memreq", mem_req, 1'b0);
        chk("rst_ccwe", cc_we, 1'b0);
        rst_n = 1'b1;
        step();
        chk("idle_en", en, 6'd0);

        // rrmovq: one enable per cycle, PC loaded at the sixth edge
        icode = 4'h2; next_pc = 64'd200;
        do_start();
        for (int i = 0; i < 6; i++) begin
            chk("rr_en", en, 6'(EN_F >> i));
            chk("rr_memreq", mem_req, 1'b0);
            chk("rr_ccwe", cc_we, 1'b0);
            step();
        end
        chk("rr_pc", pc, 64'd200);
        chk("rr_cnt", instr_count, 32'd1);
        chk("rr_refetch", en, EN_F);

        // OPq: cc_we in EXECUTE only; memory-side inputs ignored for non-memory icode
        icode = 4'h6; next_pc = 64'd10; dmem_error = 1'b1; mem_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("op_en", en, 6'(EN_F >> i));
            chk("op_ccwe", cc_we, (i == 2) ? 1'b1 : 1'b0);
            chk("op_memreq", mem_req, 1'b0);
            step();
        end
        dmem_error = 1'b0;
        chk("op_pc", pc, 64'd10);
        chk("op_cnt", instr_count, 32'd2);
        chk("op_stat", stat, 3'd1);
        chk("op_refetch", en, EN_F);

        // mrmovq: ack arrives after three waiting cycles
        icode = 4'h5; next_pc = 64'd6;
        step(); step(); step();
        for (int k = 0; k < 4; k++) begin
            chk("mr_en", en, EN_M);
            chk("mr_memreq", mem_req, 1'b1);
            mem_ack = (k == 3);
            step();
        end
        mem_ack = 1'b0;
        chk("mr_wb", en, EN_W);
        chk("mr_wb_memreq", mem_req, 1'b0);
        step(); step();
        chk("mr_pc", pc, 64'd6);
        chk("mr_cnt", instr_count, 32'd3);
        chk("mr_refetch", en, EN_F);

        // call with no ack: ADR after 15 MEMORY cycles
        icode = 4'h8; next_pc = 64'd999;
        step(); step(); step();
        for (int k = 0; k < 15; k++) begin
            chk("to_wait_en", en, EN_M);
            chk("to_wait_halted", halted, 1'b0);
            step();
        end
        chk("to_stat", stat, 3'd3);
        chk("to_halted", halted, 1'b1);
        chk("to_pc", pc, 64'd6);
        chk("to_cnt", instr_count, 32'd3);
        chk("to_en", en, 6'd0);
        chk("to_memreq", mem_req, 1'b0);
        do_start();
        step();
        chk("to_start_ignored", halted, 1'b1);
        chk("to_start_en", en, 6'd0);
        chk("to_stat_hold", stat, 3'd3);

        // halt instruction at pc 0x40
        do_reset();
        icode = 4'h1; next_pc = 64'h40;
        do_start();
        repeat (6) step();
        chk("hlt_pre_pc", pc, 64'h40);
        icode = 4'h0; next_pc = 64'h99;
        step();
        chk("hlt_stat", stat, 3'd2);
        chk("hlt_halted", halted, 1'b1);
        step(); step();
        chk("hlt_pc", pc, 64'h40);
        chk("hlt_cnt", instr_count, 32'd1);

        // invalid icode 0xC; 0xB is still a valid code
        do_reset();
        icode = 4'hC;
        do_start();
        step();
        chk("ins_stat", stat, 3'd4);
        chk("ins_halted", halted, 1'b1);
        do_reset();
        icode = 4'hB;
        do_start();
        step();
        chk("icB_decode", en, EN_D);
        chk("icB_stat", stat, 3'd1);

        // imem_error wins over a valid icode
        do_reset();
        icode = 4'h2; imem_error = 1'b1;
        do_start();
        step();
        imem_error = 1'b0;
        chk("imem_stat", stat, 3'd3);
        chk("imem_halted", halted, 1'b1);

        // dmem_error together with mem_ack
        do_reset();
        icode = 4'h4; next_pc = 64'h77;
        do_start();
        step(); step(); step();
        chk("dm_memreq", mem_req, 1'b1);
        dmem_error = 1'b1; mem_ack = 1'b1;
        step();
        dmem_error = 1'b0; mem_ack = 1'b0;
        chk("dm_stat", stat, 3'd3);
        chk("dm_halted", halted, 1'b1);
        chk("dm_pc", pc, 64'd0);
        chk("dm_cnt", instr_count, 32'd0);

        // reset in the middle of a memory wait
        do_reset();
        icode = 4'h2; next_pc = 64'h80;
        do_start();
        repeat (6) step();
        icode = 4'hA;
        step(); step(); step(); step();
        chk("mr_rst_pre_memreq", mem_req, 1'b1);
        chk("mr_rst_pre_pc", pc, 64'h80);
        rst_n = 1'b0;
        step();
        chk("mr_rst_pc", pc, 64'd0);
        chk("mr_rst_en", en, 6'd0);
        chk("mr_rst_memreq", mem_req, 1'b0);
        chk("mr_rst_stat", stat, 3'd1);
        chk("mr_rst_cnt", instr_count, 32'd0);
        chk("mr_rst_halted", halted, 1'b0);
        rst_n = 1'b1;
        step();
        chk("mr_rst_idle", en, 6'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
